// File: rtl/tsp_result_display.sv
// tsp_result_display
// Accepts one binary tour cost per valid/ready handshake, converts it to six
// BCD digits with a one-bit-per-cycle double-dabble engine and drives six
// registered, active-low seven-segment outputs (HEX0 = least-significant digit).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a handshake; in_ready high
// CONV  | one add-3/shift step per cycle, WIDTH steps in total
// LOAD  | copy the finished BCD into the held display registers, pulse done
module tsp_result_display #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             lz_en,
    input  logic             blank,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    // Largest value that fits in six decimal digits.
    localparam logic [WIDTH-1:0] MAX_BCD = WIDTH'(999999);

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t           state_q,        state_d;
    logic [WIDTH-1:0] shift_q,        shift_d;
    logic [23:0]      bcd_q,          bcd_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic             ovf_q,          ovf_d;
    logic [23:0]      held_digits_q,  held_digits_d;
    logic             held_ovf_q,     held_ovf_d;
    logic             shown_q,        shown_d;
    logic             done_q,         done_d;
    logic             busy_q,         busy_d;
    logic [5:0][6:0]  hex_q,          hex_d;

    logic [23:0]      bcd_adj;

    // Active-low segment pattern for one decimal digit; anything above 9 is dark.
    function automatic logic [6:0] seg7(input logic [3:0] dig);
        logic [6:0] seg;
        case (dig)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DARK;
        endcase
        return seg;
    endfunction

    assign in_ready = (state_q == IDLE);
    assign busy     = busy_q;
    assign done     = done_q;
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Handshake capture, conversion stepping and result hand-off.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        held_digits_d = held_digits_q;
        held_ovf_d    = held_ovf_q;
        shown_d       = shown_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (in_value > MAX_BCD);
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d   = {bcd_adj[22:0], shift_q[WIDTH-1]};
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                held_digits_d = bcd_q;
                held_ovf_d    = ovf_q;
                shown_d       = 1'b1;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Segment image from held state; leading digits go dark above the top non-zero one.
    always_comb begin
        logic       seen;
        logic [3:0] dig;
        hex_d = {6{SEG_DARK}};
        seen  = 1'b0;
        dig   = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            dig = held_digits_q[4*i +: 4];
            if (dig != 4'd0) begin
                seen = 1'b1;
            end
            if (blank || !shown_q) begin
                hex_d[i] = SEG_DARK;
            end else if (held_ovf_q) begin
                hex_d[i] = SEG_DASH;
            end else if (lz_en && !seen && (i != 0)) begin
                hex_d[i] = SEG_DARK;
            end else begin
                hex_d[i] = seg7(dig);
            end
        end
    end

    // State and output registers; reset aborts any conversion and darkens the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            held_digits_q <= '0;
            held_ovf_q    <= 1'b0;
            shown_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            hex_q         <= {6{SEG_DARK}};
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            held_digits_q <= held_digits_d;
            held_ovf_q    <= held_ovf_d;
            shown_q       <= shown_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            hex_q         <= hex_d;
        end
    end

endmodule

// File: tb/tb_tsp_result_display.sv
// Self-checking bench for tsp_result_display: directed scenarios plus random
// values, compared against a decimal-arithmetic display model.
module tb_tsp_result_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_value;
    logic        lz_en;
    logic        blank;
    logic        busy;
    logic        done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hex_all;

    int pass_cnt  = 0;
    int total_cnt = 0;

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #5 clk = ~clk;

    tsp_result_display #(.WIDTH(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .lz_en    (lz_en),
        .blank    (blank),
        .busy     (busy),
        .done     (done),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {HEX5..HEX0} for a displayed value, using decimal arithmetic.
    function automatic logic [41:0] exp_hex(input int v, input bit lz, input bit blk, input bit shown);
        logic [41:0] r;
        int p;
        r = '1;
        if (blk || !shown) return r;
        if (v > 999999) return {6{7'h3F}};
        p = 1;
        for (int i = 0; i < 6; i++) begin
            if (lz && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
            else                      r[7*i +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake v, then wait out the full 22-cycle latency.
    task automatic conv(input int v);
        in_valid = 1'b1;
        in_value = v[19:0];
        step();
        in_valid = 1'b0;
        repeat (22) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; lz_en = 1'b0; blank = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b want 1 0 0", in_ready, busy, done);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (hex_all !== exp_hex(0, 0, 0, 0))
            $display("FAIL reset_hex: got %h want %h", hex_all, exp_hex(0, 0, 0, 0));
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int rl = 0;
        int dn = 0;
        lz_en = 1'b0;
        in_valid = 1'b1;
        in_value = 20'd123456;
        step();
        in_valid = 1'b0;
        if (!in_ready) rl++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
        else pass_cnt++;
        for (int k = 1; k <= 22; k++) begin
            step();
            if (k <= 21 && !in_ready) rl++;
            if (done) dn++;
            if (k == 21) begin
                total_cnt++;
                if (hex_all !== exp_hex(0, 0, 0, 0))
                    $display("FAIL basic_hold_prev: got %h want %h", hex_all, exp_hex(0, 0, 0, 0));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (hex_all !== exp_hex(123456, 0, 0, 1))
            $display("FAIL basic_hex: got %h want %h", hex_all, exp_hex(123456, 0, 0, 1));
        else pass_cnt++;
        total_cnt++;
        if (rl !== 21) $display("FAIL basic_ready_low: got %0d cycles want 21", rl);
        else pass_cnt++;
        total_cnt++;
        if (dn !== 1) $display("FAIL basic_done: got %0d pulses want 1", dn);
        else pass_cnt++;
    endtask

    task automatic test_lz();
        lz_en = 1'b1;
        conv(42);
        total_cnt++;
        if (hex_all !== exp_hex(42, 1, 0, 1))
            $display("FAIL lz_42: got %h want %h", hex_all, exp_hex(42, 1, 0, 1));
        else pass_cnt++;
        lz_en = 1'b0;
        step();
        total_cnt++;
        if (hex_all !== exp_hex(42, 0, 0, 1))
            $display("FAIL lz_off_42: got %h want %h", hex_all, exp_hex(42, 0, 0, 1));
        else pass_cnt++;
        lz_en = 1'b1;
        conv(0);
        total_cnt++;
        if (hex_all !== exp_hex(0, 1, 0, 1))
            $display("FAIL lz_zero: got %h want %h", hex_all, exp_hex(0, 1, 0, 1));
        else pass_cnt++;
    endtask

    task automatic test_ovf();
        int vals[3] = '{1000000, 1048575, 999999};
        lz_en = 1'b0;
        foreach (vals[i]) begin
            conv(vals[i]);
            total_cnt++;
            if (hex_all !== exp_hex(vals[i], 0, 0, 1))
                $display("FAIL ovf_%0d: got %h want %h", vals[i], hex_all, exp_hex(vals[i], 0, 0, 1));
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int dn = 0;
        lz_en = 1'b0;
        in_valid = 1'b1;
        in_value = 20'd111111;
        step();
        in_value = 20'd222222;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k == 22) in_valid = 1'b0;
            if (done) dn++;
            if (k == 22 || k == 43) begin
                total_cnt++;
                if (hex_all !== exp_hex(111111, 0, 0, 1))
                    $display("FAIL b2b_first_k%0d: got %h want %h", k, hex_all, exp_hex(111111, 0, 0, 1));
                else pass_cnt++;
            end
            if (k == 22) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: got ready=%b want 0", in_ready);
                else pass_cnt++;
            end
            if (k == 44) begin
                total_cnt++;
                if (hex_all !== exp_hex(222222, 0, 0, 1))
                    $display("FAIL b2b_second: got %h want %h", hex_all, exp_hex(222222, 0, 0, 1));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (dn !== 2) $display("FAIL b2b_done: got %0d pulses want 2", dn);
        else pass_cnt++;
    endtask

    task automatic test_blank();
        lz_en = 1'b0;
        conv(654321);
        blank = 1'b1;
        step();
        total_cnt++;
        if (hex_all !== exp_hex(654321, 0, 1, 1))
            $display("FAIL blank_on: got %h want %h", hex_all, exp_hex(654321, 0, 1, 1));
        else pass_cnt++;
        blank = 1'b0;
        step();
        total_cnt++;
        if (hex_all !== exp_hex(654321, 0, 0, 1))
            $display("FAIL blank_off: got %h want %h", hex_all, exp_hex(654321, 0, 0, 1));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        lz_en = 1'b1;
        in_valid = 1'b1;
        in_value = 20'd500000;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (hex_all !== exp_hex(0, 0, 0, 0) || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_mid_now: got hex=%h ready=%b busy=%b want %h 1 0",
                     hex_all, in_ready, busy, exp_hex(0, 0, 0, 0));
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done) dn++;
        end
        total_cnt++;
        if (dn !== 0 || hex_all !== exp_hex(0, 0, 0, 0))
            $display("FAIL rst_mid_after: got done=%0d hex=%h want 0 %h", dn, hex_all, exp_hex(0, 0, 0, 0));
        else pass_cnt++;
        conv(7);
        total_cnt++;
        if (hex_all !== exp_hex(7, 1, 0, 1))
            $display("FAIL rst_mid_seven: got %h want %h", hex_all, exp_hex(7, 1, 0, 1));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int v;
        bit lz;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 999999));
                2:       v = int'($urandom_range(1000000, 1048575));
                default: v = int'($urandom_range(0, 1048575));
            endcase
            lz = 1'($urandom_range(0, 1));
            lz_en = lz;
            conv(v);
            total_cnt++;
            if (hex_all !== exp_hex(v, lz, 0, 1))
                $display("FAIL rand_%0d v=%0d lz=%0d: got %h want %h", n, v, lz, hex_all, exp_hex(v, lz, 0, 1));
            else pass_cnt++;
            lz_en = ~lz;
            step();
            total_cnt++;
            if (hex_all !== exp_hex(v, ~lz, 0, 1))
                $display("FAIL rand_lz_%0d v=%0d: got %h want %h", n, v, hex_all, exp_hex(v, ~lz, 0, 1));
            else pass_cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_ovf();
        test_back_to_back();
        test_blank();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tsp_result_display.md
# tsp_result_display

Sequential result-to-display driver for the TSP FPGA top level. It accepts one binary tour cost per valid/ready handshake and converts it to six BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per cycle. It then drives the six active-low seven-segment outputs HEX0–HEX5 that the top-level bench and the DE-board pins observe. It sits between the solver core's result port and the HEX pins and replaces any combinational binary-to-segment path.

## Interface
- WIDTH, 20: width of in_value; covers 0..999999 plus overflow detection.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  result on in_value is valid.
- in_ready  out  1  block can accept; high only in IDLE (combinational from state).
- in_value  in  WIDTH  unsigned tour cost.
- lz_en  in  1  leading-zero suppression enable (board SW[0]).
- blank  in  1  force all digits dark (board SW[1]); sampled every cycle.
- busy  out  1  high in CONV or LOAD.
- done  out  1  one-cycle pulse after the display digits update.
- HEX0..HEX5  out  7 each  segments, active-low, bit0=a .. bit6=g; HEX0 = least-significant digit.

## Operation
- FSM states: IDLE, CONV, LOAD.
- IDLE: a handshake (in_valid && in_ready at posedge) captures in_value into the shift register, clears the 24-bit BCD register and the bit counter, and latches ovf = (in_value > 999999). Next state is CONV.
- CONV, per cycle: each BCD nibble >= 5 gets +3; then {bcd, shift} shifts left by 1. The counter increments. After the WIDTH-th shift the next state is LOAD.
- LOAD: copies bcd into the held digit register, copies ovf into held_ovf, sets shown = 1, pulses done on the following cycle, and returns to IDLE.
- in_valid outside IDLE is ignored; no queuing.
- Segment register, updated every cycle from held state:
  - blank = 1 or shown = 0: all HEX = 7'h7F.
  - held_ovf = 1: all HEX = 7'h3F (dash).
  - Otherwise each digit is encoded 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex).
  - With lz_en = 1, digits above the most-significant non-zero digit are 7'h7F. HEX0 is always shown, so value 0 displays "0".
- Nibble values above 9 cannot occur for inputs ≤ 999999. The encoder maps any out-of-range nibble to 7'h7F.

## Timing
- Reset values: state IDLE, in_ready = 1, busy = 0, done = 0, shown = 0, held digits = 0, held_ovf = 0, all HEX = 7'h7F.
- Reset is asynchronous at any time, including mid-CONV: the conversion is aborted, the result is discarded, and the display goes dark.
- Handshake at edge T0. CONV occupies edges T1..T20, with state = LOAD after T20. The held registers update at T21. done is high for exactly the cycle after T21. HEX reflects the new value after T22, i.e. 22 cycles of latency.
- in_ready goes low after T0 and returns high after T21. The earliest next acceptance is T22, giving a throughput of one result per 22 cycles.
- blank and lz_en take effect one cycle after they change. They do not disturb the held digits or a conversion in progress.
- When a new result loads, the previous value stays displayed until the T22 update; there is no intermediate blank.

## Test plan
- Reset, then in_value = 123456 with lz_en = 0. Required: in_ready drops for 21 cycles, done pulses once, and 22 cycles after the handshake HEX5..HEX0 = 79,24,30,19,12,02.
- in_value = 42. With lz_en = 1: HEX0 = 24, HEX1 = 19, HEX2..HEX5 = 7F. Toggle lz_en to 0: HEX2..HEX5 = 40 one cycle later. Then in_value = 0 with lz_en = 1: HEX0 = 40, the rest 7F.
- in_value = 1000000 and in_value = 1048575: all HEX = 3F. Follow with 999999: all HEX = 10.
- Hold in_valid high with 111111, then 222222, on consecutive cycles. Required: only the first is accepted; the second is accepted at T22 and displayed at T44; done pulses exactly twice.
- Display 654321, then assert blank: all HEX = 7F one cycle later. Deassert blank: 654321 returns with no new handshake.
- Assert rst_n low at T10 of a conversion for 3 cycles. Required: HEX = 7F immediately and in_ready = 1, with no done. A subsequent 7 with lz_en = 1 displays HEX0 = 78.
